// File: rtl/main_top.sv
// Brushed-DC motor demo: debounced mode button, five-mode FSM, PWM H-bridge drive with dead time.
// state | meaning: STOP idle | FWD_SLOW/FWD_FAST IN1 50%/100% | REV_SLOW/REV_FAST IN2 50%/100%
module main_top #(
  parameter int CLK_HZ           = 12_000_000,
  parameter int PWM_HZ           = 20_000,
  parameter int DEBOUNCE_CYCLES  = 120_000,
  parameter int DEAD_CYCLES      = 1_200,
  parameter int HEARTBEAT_CYCLES = 6_000_000
) (
  input  logic       clk,
  input  logic [1:0] buttons,
  output logic [1:0] motor,
  output logic [2:0] rgb,
  output logic [7:0] pmod,
  output logic [1:0] leds
);
  localparam int PWM_PERIOD = CLK_HZ / PWM_HZ;
  localparam int PW  = $clog2(PWM_PERIOD + 1);
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DW  = $clog2(DEAD_CYCLES + 1);
  localparam int HW  = $clog2(HEARTBEAT_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_STOP     = 3'd0,
    ST_FWD_SLOW = 3'd1,
    ST_FWD_FAST = 3'd2,
    ST_REV_SLOW = 3'd3,
    ST_REV_FAST = 3'd4
  } mode_e;

  logic           rst_pin_n, rst_n;
  logic [1:0]     rst_sync_q, rst_sync_d;
  logic [1:0]     btn_sync_q, btn_sync_d;
  logic           deb_level_q, deb_level_d, deb_prev_q, deb_prev_d;
  logic [DBW-1:0] deb_cnt_q, deb_cnt_d;
  mode_e          mode_q, mode_d;
  logic [DW-1:0]  dead_cnt_q, dead_cnt_d;
  logic [PW-1:0]  pwm_cnt_q, pwm_cnt_d, duty;
  logic [HW-1:0]  hb_cnt_q, hb_cnt_d;
  logic           hb_q, hb_d;
  logic [1:0]     motor_q, motor_d;
  logic [2:0]     rgb_q, rgb_d;
  logic [7:0]     pmod_q, pmod_d;
  logic           advance, mode_change, dead_active, pwm;

  // Reset asserts asynchronously but releases only after two clock edges.
  assign rst_pin_n  = buttons[0];
  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign rst_n      = rst_sync_q[1];

  always_ff @(posedge clk or negedge rst_pin_n) begin
    if (!rst_pin_n) rst_sync_q <= 2'b00;
    else            rst_sync_q <= rst_sync_d;
  end

  always_comb begin
    btn_sync_d  = {btn_sync_q[0], buttons[1]};
    deb_level_d = deb_level_q;
    deb_cnt_d   = '0;
    if (btn_sync_q[1] != deb_level_q) begin
      if (deb_cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) deb_level_d = btn_sync_q[1];
      else                                        deb_cnt_d   = deb_cnt_q + DBW'(1);
    end
    deb_prev_d = deb_level_q;
    advance    = deb_level_q & ~deb_prev_q;

    mode_d = mode_q;
    case (mode_q)
      ST_STOP:     if (advance) mode_d = ST_FWD_SLOW;
      ST_FWD_SLOW: if (advance) mode_d = ST_FWD_FAST;
      ST_FWD_FAST: if (advance) mode_d = ST_REV_SLOW;
      ST_REV_SLOW: if (advance) mode_d = ST_REV_FAST;
      ST_REV_FAST: if (advance) mode_d = ST_STOP;
      default:                  mode_d = ST_STOP;
    endcase
    mode_change = (mode_d != mode_q);

    dead_active = (dead_cnt_q != '0);
    if (mode_change)      dead_cnt_d = DW'(DEAD_CYCLES);
    else if (dead_active) dead_cnt_d = dead_cnt_q - DW'(1);
    else                  dead_cnt_d = dead_cnt_q;

    if (mode_change || pwm_cnt_q == PW'(PWM_PERIOD - 1)) pwm_cnt_d = '0;
    else                                                 pwm_cnt_d = pwm_cnt_q + PW'(1);

    case (mode_q)
      ST_FWD_SLOW, ST_REV_SLOW: duty = PW'(PWM_PERIOD / 2);
      ST_FWD_FAST, ST_REV_FAST: duty = PW'(PWM_PERIOD);
      default:                  duty = '0;
    endcase
    pwm = (pwm_cnt_q < duty);

    motor_d = 2'b00;
    rgb_d   = 3'b011;
    if (dead_active) begin
      rgb_d = 3'b111;
    end else begin
      case (mode_q)
        ST_FWD_SLOW, ST_FWD_FAST: begin motor_d = {1'b0, pwm}; rgb_d = 3'b101; end
        ST_REV_SLOW, ST_REV_FAST: begin motor_d = {pwm, 1'b0}; rgb_d = 3'b110; end
        default: ;
      endcase
    end

    hb_cnt_d = hb_cnt_q + HW'(1);
    hb_d     = hb_q;
    if (hb_cnt_q == HW'(HEARTBEAT_CYCLES - 1)) begin
      hb_cnt_d = '0;
      hb_d     = ~hb_q;
    end

    // Snapshot taken alongside motor/rgb so the debug bus lines up with the pins.
    pmod_d = {mode_q, pwm, motor_d, dead_active, hb_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync_q  <= 2'b00;
      deb_level_q <= 1'b0;
      deb_prev_q  <= 1'b0;
      deb_cnt_q   <= '0;
      mode_q      <= ST_STOP;
      dead_cnt_q  <= '0;
      pwm_cnt_q   <= '0;
      hb_cnt_q    <= '0;
      hb_q        <= 1'b0;
      motor_q     <= 2'b00;
      rgb_q       <= 3'b011;
      pmod_q      <= 8'h00;
    end else begin
      btn_sync_q  <= btn_sync_d;
      deb_level_q <= deb_level_d;
      deb_prev_q  <= deb_prev_d;
      deb_cnt_q   <= deb_cnt_d;
      mode_q      <= mode_d;
      dead_cnt_q  <= dead_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      hb_cnt_q    <= hb_cnt_d;
      hb_q        <= hb_d;
      motor_q     <= motor_d;
      rgb_q       <= rgb_d;
      pmod_q      <= pmod_d;
    end
  end

  assign motor = motor_q;
  assign rgb   = rgb_q;
  assign pmod  = pmod_q;
  assign leds  = {deb_level_q, hb_q};
endmodule

// File: tb/tb_main_top.sv
// Scoreboard bench for main_top: expected mode codes are queued at each press and popped as pmod reports them.
module tb_main_top;
  logic       clk = 1'b0;
  logic [1:0] buttons;
  logic [1:0] motor;
  logic [2:0] rgb;
  logic [7:0] pmod;
  logic [1:0] leds;

  int checks = 0;
  int failures = 0;
  int exp_mode = 0;
  int bad11 = 0;
  bit mon_en = 0;
  logic [2:0] exp_q[$];

  main_top #(
    .DEBOUNCE_CYCLES(4),
    .DEAD_CYCLES(10),
    .HEARTBEAT_CYCLES(8)
  ) dut (
    .clk(clk),
    .buttons(buttons),
    .motor(motor),
    .rgb(rgb),
    .pmod(pmod),
    .leds(leds)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press();
    exp_mode = (exp_mode + 1) % 5;
    exp_q.push_back(3'(exp_mode));
    buttons[1] = 1'b1;
    cycles(12);
    buttons[1] = 1'b0;
    cycles(12);
  endtask

  task automatic hb_interval(output int n);
    logic p;
    p = leds[0];
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (leds[0] === p && n < 40);
  endtask

  // Mode monitor: every change seen on pmod[7:5] must match the next queued code.
  initial begin
    logic [2:0] last;
    last = 3'd0;
    forever begin
      @(negedge clk);
      if (motor === 2'b11) bad11++;
      if (!mon_en || buttons[0] !== 1'b1) begin
        last = pmod[7:5];
      end else if (pmod[7:5] !== last) begin
        last = pmod[7:5];
        if (exp_q.size() == 0) check_eq("mode_unexpected", 32'(last), 32'(exp_mode) + 32'h100);
        else                   check_eq("mode_seq", 32'(last), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int n, hi, lo, m0hi, m1hi;
    logic p;
    buttons = 2'b00;
    cycles(3);
    check_eq("rst_motor", 32'(motor), 32'h0);
    check_eq("rst_rgb", 32'(rgb), 32'h3);
    check_eq("rst_leds", 32'(leds), 32'h0);
    check_eq("rst_pmod", 32'(pmod), 32'h0);
    #1 buttons[0] = 1'b1;
    mon_en = 1'b1;

    hb_interval(n);
    hb_interval(n);
    check_eq("hb_period_a", 32'(n), 32'd8);
    hb_interval(n);
    check_eq("hb_period_b", 32'(n), 32'd8);

    for (int i = 0; i < 10; i++) begin
      buttons[1] = ~buttons[1];
      cycles(2);
    end
    cycles(4);
    check_eq("bounce_level", 32'(leds[1]), 32'h0);
    check_eq("bounce_mode", 32'(pmod[7:5]), 32'h0);
    exp_mode = 1;
    exp_q.push_back(3'd1);
    buttons[1] = 1'b1;
    cycles(10);
    check_eq("deb_level_hi", 32'(leds[1]), 32'h1);
    buttons[1] = 1'b0;
    cycles(14);
    check_eq("fwd_slow_rgb", 32'(rgb), 32'h5);

    n = 0;
    p = motor[0];
    m1hi = 0;
    do begin
      p = motor[0];
      @(negedge clk);
      n++;
      if (motor[1]) m1hi++;
    end while (!(motor[0] && !p) && n < 1300);
    hi = 0;
    while (motor[0] && hi < 700) begin
      @(negedge clk);
      hi++;
      if (motor[1]) m1hi++;
    end
    lo = 0;
    while (!motor[0] && lo < 700) begin
      @(negedge clk);
      lo++;
      if (motor[1]) m1hi++;
    end
    check_eq("fwd_slow_high", 32'(hi), 32'd300);
    check_eq("fwd_slow_low", 32'(lo), 32'd300);
    check_eq("fwd_slow_in2", 32'(m1hi), 32'd0);

    press();
    check_eq("fwd_fast_motor", 32'(motor), 32'h1);
    check_eq("fwd_fast_rgb", 32'(rgb), 32'h5);

    exp_mode = 3;
    exp_q.push_back(3'd3);
    buttons[1] = 1'b1;
    n = 0;
    while (pmod[7:5] !== 3'd3 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("rev_slow_seen", 32'(pmod[7:5]), 32'h3);
    check_eq("dead_flag", 32'(pmod[1]), 32'h1);
    n = 0;
    while (rgb === 3'b111 && motor === 2'b00 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check_eq("dead_len", 32'(n), 32'd10);
    check_eq("rev_slow_rgb", 32'(rgb), 32'h6);
    buttons[1] = 1'b0;
    m0hi = 0;
    m1hi = 0;
    repeat (700) begin
      @(negedge clk);
      if (motor[0]) m0hi++;
      if (motor[1]) m1hi++;
    end
    check_eq("rev_in1_low", 32'(m0hi), 32'd0);
    check_eq("rev_in2_pulses", 32'(m1hi >= 300 && m1hi <= 400), 32'd1);

    press();
    check_eq("rev_fast_motor", 32'(motor), 32'h2);
    press();
    cycles(10);
    check_eq("wrap_rgb", 32'(rgb), 32'h3);
    check_eq("wrap_motor", 32'(motor), 32'h0);

    press();
    cycles(20);
    @(negedge clk);
    #1 buttons[0] = 1'b0;
    #1;
    check_eq("async_rst_motor", 32'(motor), 32'h0);
    check_eq("async_rst_rgb", 32'(rgb), 32'h3);
    check_eq("async_rst_leds", 32'(leds), 32'h0);
    check_eq("async_rst_pmod", 32'(pmod), 32'h0);
    cycles(2);
    #1 buttons[0] = 1'b1;
    exp_mode = 0;
    cycles(6);
    check_eq("post_rst_mode", 32'(pmod[7:5]), 32'h0);
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    check_eq("never_11", 32'(bad11), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/main_top.md
Name: main_top

Overview:
- Top-level board block for the brushed-DC motor demo on a 12 MHz FPGA board.
- Debounces a mode button and steps through five drive modes: stop, forward slow/fast, reverse slow/fast.
- Generates a PWM H-bridge drive with dead time on every mode change.
- Reports status on the RGB LED, user LEDs and a PMOD debug header.

Parameters:
- CLK_HZ, 12_000_000, system clock frequency in Hz.
- PWM_HZ, 20_000, PWM frequency; PWM_PERIOD = CLK_HZ/PWM_HZ (600 cycles).
- DEBOUNCE_CYCLES, 120_000, cycles the synchronized button must stay stable before it is accepted (10 ms).
- DEAD_CYCLES, 1_200, cycles both motor outputs are forced low after a mode change (100 us).
- HEARTBEAT_CYCLES, 6_000_000, half-period of the heartbeat blink (1 Hz blink).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- buttons  input  2  [0] = reset, asynchronous, active-low; [1] = mode button, active-high, asynchronous to clk.
- motor  output  2  H-bridge inputs: [0] = IN1 (forward), [1] = IN2 (reverse).
- rgb  output  3  {red, green, blue}, active-low (0 = LED on).
- pmod  output  8  debug bus.
- leds  output  2  [0] = heartbeat, [1] = debounced button state.

Behaviour:
- Reset:
  - buttons[0] low asynchronously clears every register: mode=STOP, PWM counter=0, dead counter=0, debounce state=0, heartbeat=0.
  - Outputs during/after reset: motor=2'b00, rgb=3'b011 (red), leds=2'b00, pmod=8'h00.
  - Deassertion is synchronized with a 2-FF release.
- Button path:
  - buttons[1] passes through a 2-FF synchronizer.
  - The debounced level updates only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
  - A 0->1 transition of the debounced level produces a one-cycle advance pulse.
- Mode FSM (3-bit code):
  - STOP(0) -> FWD_SLOW(1) -> FWD_FAST(2) -> REV_SLOW(3) -> REV_FAST(4) -> STOP(0); wraps.
  - Advances on the pulse only. Holding the button advances once.
  - Codes 5-7 are illegal and go to STOP.
- Dead time:
  - Every mode change loads the dead counter with DEAD_CYCLES and restarts the PWM counter at 0.
  - While the dead counter is nonzero: motor=00, rgb=3'b111, dead_active=1.
  - A mode change during dead time reloads the counter.
- PWM:
  - Counter runs 0..PWM_PERIOD-1, then wraps to 0.
  - pwm = (counter < duty). duty is PWM_PERIOD/2 for SLOW, PWM_PERIOD for FAST (constant high), 0 for STOP.
- Motor drive (outside dead time):
  - FWD modes: motor = {1'b0, pwm}.
  - REV modes: motor = {pwm, 1'b0}.
  - STOP: motor = 00.
  - motor is registered, so it is one cycle behind the counter. motor=2'b11 must never occur.
- RGB (outside dead time):
  - STOP: 3'b011 (red).
  - FWD modes: 3'b101 (green).
  - REV modes: 3'b110 (blue).
- Heartbeat: leds[0] toggles every HEARTBEAT_CYCLES.
- leds[1]: equals the debounced button level.
- pmod (registered): {mode[2:0], pwm, motor[1], motor[0], dead_active, leds[0]}.

Test Plan:
- Reset: hold buttons[0]=0 for 2 cycles mid-run -> motor=00, rgb=011, leds=00, pmod=00 immediately, asynchronously, without waiting for a clock edge.
- Debounce (DEBOUNCE_CYCLES=4): toggle buttons[1] every 2 cycles for 20 cycles, then hold 1 for 10 cycles -> exactly one mode advance, STOP->FWD_SLOW; leds[1]=1 after stable hold.
- FWD_SLOW (PWM_PERIOD=600, DEAD_CYCLES=10): after dead time expires, motor[0] high 300 cycles, low 300 cycles; motor[1]=0; rgb=101.
- Dead time (DEAD_CYCLES=10): step FWD_FAST->REV_SLOW -> motor=00 and rgb=111 for 10 cycles, then motor[1] pulses and motor[0] stays 0; motor never 11.
- Wrap: issue 5 presses from STOP -> mode sequence 1,2,3,4,0; pmod[7:5] matches each code; final rgb=011.
- Heartbeat (HEARTBEAT_CYCLES=8): leds[0] toggles every 8 cycles after reset release.
